// File: rtl/matrix_print_sched.sv
// matrix_print_sched
//   Shares one matrix_uart_sender between two matrix-print requesters
//   (slot 0 = matrix_gen, slot 1 = ALU result path). The granted matrix is
//   walked out of a row-major store through a 1-cycle-latency read port, one
//   sender command per element, with an optional ID line before the matrix
//   and an optional blank line after it. The requester is acked when done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req[1:0]            level request per slot, held until ack
//   req_base/rows/cols  per-slot matrix geometry (slot 0 in the low field)
//   req_id, req_show_id per-slot ID value and ID-line enable
//   ack[1:0], err       one-cycle completion pulse, err when a dimension is 0
//   busy, grant         transfer in progress, current/last granted slot
//   mem_rd_en/addr      store read strobe and address
//   mem_rd_data         store data, valid the cycle after mem_rd_en
//   snd_start           number command pulse (data, row-end flag, ID mode)
//   snd_newline         newline-only command pulse
//   snd_data, snd_last_col, snd_send_id  command operands, held between commands
//   snd_ready, snd_done sender idle level and per-command completion pulse
module matrix_print_sched #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DIM_W    = 3,
  parameter int TRAIL_NL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [2*ADDR_W-1:0]   req_base,
  input  logic [2*DIM_W-1:0]    req_rows,
  input  logic [2*DIM_W-1:0]    req_cols,
  input  logic [2*DATA_W-1:0]   req_id,
  input  logic [1:0]            req_show_id,
  output logic [1:0]            ack,
  output logic                  err,
  output logic                  busy,
  output logic                  grant,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  snd_start,
  output logic [DATA_W-1:0]     snd_data,
  output logic                  snd_last_col,
  output logic                  snd_send_id,
  output logic                  snd_newline,
  input  logic                  snd_ready,
  input  logic                  snd_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_ID_CMD, S_ID_WAIT, S_RD_ADDR, S_RD_DATA,
    S_EL_CMD, S_EL_WAIT, S_NL_CMD, S_NL_WAIT, S_FINISH
  } state_t;

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  state_t                    state_q, state_d;
  logic                      grant_q;
  logic                      last_q;        // arbiter memory, separate from the visible grant
  logic [ADDR_W-1:0]         base_q;
  logic [DIM_W-1:0]          rows_q, cols_q;
  logic [DATA_W-1:0]         id_q;
  logic                      show_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [DIM_W-1:0]          r_q, c_q;
  logic                      err_q;
  logic signed [DATA_W-1:0]  data_q;
  logic                      last_col_q;
  logic                      send_id_q;

  logic pick;
  logic dims_zero;
  logic c_last, r_last;

  // With both requests pending the slot not served last wins.
  assign pick      = (req == 2'b11) ? ~last_q : req[1];
  assign dims_zero = (rows_q == '0) || (cols_q == '0);
  assign c_last    = (c_q == (cols_q - DIM_ONE));
  assign r_last    = (r_q == (rows_q - DIM_ONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|req) state_d = S_GRANT;
      S_GRANT: begin
        if (dims_zero)   state_d = S_FINISH;
        else if (show_q) state_d = S_ID_CMD;
        else             state_d = S_RD_ADDR;
      end
      S_ID_CMD:  if (snd_ready) state_d = S_ID_WAIT;
      S_ID_WAIT: if (snd_done)  state_d = S_RD_ADDR;
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_EL_CMD;
      S_EL_CMD:  if (snd_ready) state_d = S_EL_WAIT;
      S_EL_WAIT: begin
        if (snd_done) begin
          if (!c_last || !r_last) state_d = S_RD_ADDR;
          else if (TRAIL_NL != 0) state_d = S_NL_CMD;
          else                    state_d = S_FINISH;
        end
      end
      S_NL_CMD:  if (snd_ready) state_d = S_NL_WAIT;
      S_NL_WAIT: if (snd_done)  state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode; command pulses are gated by snd_ready so each *_CMD
  // state emits exactly one pulse on the cycle it leaves.
  always_comb begin
    ack         = 2'b00;
    err         = 1'b0;
    busy        = (state_q != S_IDLE);
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    snd_start   = 1'b0;
    snd_newline = 1'b0;
    case (state_q)
      S_ID_CMD, S_EL_CMD: snd_start   = snd_ready;
      S_NL_CMD:           snd_newline = snd_ready;
      S_RD_ADDR: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
      end
      S_FINISH: begin
        ack = grant_q ? 2'b10 : 2'b01;
        err = err_q;
      end
      default: ;
    endcase
  end

  assign grant        = grant_q;
  assign snd_data     = data_q;
  assign snd_last_col = last_col_q;
  assign snd_send_id  = send_id_q;

  // Datapath: request latch, walk counters, sender operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      base_q     <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      id_q       <= '0;
      show_q     <= 1'b0;
      addr_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      last_col_q <= 1'b0;
      send_id_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            grant_q <= pick;
            last_q  <= pick;
            base_q  <= pick ? req_base[2*ADDR_W-1:ADDR_W] : req_base[ADDR_W-1:0];
            rows_q  <= pick ? req_rows[2*DIM_W-1:DIM_W]   : req_rows[DIM_W-1:0];
            cols_q  <= pick ? req_cols[2*DIM_W-1:DIM_W]   : req_cols[DIM_W-1:0];
            id_q    <= pick ? req_id[2*DATA_W-1:DATA_W]   : req_id[DATA_W-1:0];
            show_q  <= pick ? req_show_id[1]              : req_show_id[0];
          end
        end
        S_GRANT: begin
          r_q    <= '0;
          c_q    <= '0;
          addr_q <= base_q;
          err_q  <= dims_zero;
          // The ID operands are staged here so they are already stable
          // when the ID command pulse goes out.
          if (show_q && !dims_zero) begin
            data_q     <= $signed(id_q);
            last_col_q <= 1'b1;
            send_id_q  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          data_q     <= $signed(mem_rd_data);
          last_col_q <= c_last;
          send_id_q  <= 1'b0;
        end
        S_EL_WAIT: begin
          if (snd_done) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (!c_last) begin
              c_q <= c_q + DIM_ONE;
            end else if (!r_last) begin
              c_q <= '0;
              r_q <= r_q + DIM_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_print_sched.sv
// Scoreboard bench for matrix_print_sched. Stimulus pushes the expected
// reads, sender commands and acks of each request; a monitor pops them as
// the DUT presents the matching strobes. A memory model and a sender model
// answer the DUT's handshakes.
module tb_matrix_print_sched;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int DIM_W    = 3;
  localparam int TRAIL_NL = 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          req;
  logic [2*ADDR_W-1:0] req_base;
  logic [2*DIM_W-1:0]  req_rows, req_cols;
  logic [2*DATA_W-1:0] req_id;
  logic [1:0]          req_show_id;
  logic [1:0]          ack;
  logic                err, busy, grant, mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rd_data;
  logic                snd_start, snd_last_col, snd_send_id, snd_newline;
  logic [DATA_W-1:0]   snd_data;
  logic                snd_ready, snd_done;

  always #5 clk = ~clk;

  matrix_print_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .TRAIL_NL(TRAIL_NL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_base(req_base), .req_rows(req_rows),
    .req_cols(req_cols), .req_id(req_id), .req_show_id(req_show_id), .ack(ack),
    .err(err), .busy(busy), .grant(grant), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .snd_start(snd_start), .snd_data(snd_data),
    .snd_last_col(snd_last_col), .snd_send_id(snd_send_id), .snd_newline(snd_newline),
    .snd_ready(snd_ready), .snd_done(snd_done));

  typedef struct { bit nl; bit sid; bit lc; logic [DATA_W-1:0] d; } cmd_t;
  typedef struct { logic [1:0] a; bit e; } ack_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  cmd_t              cmd_q[$];
  ack_t              ack_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  chk_t              chk_q[$];
  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] mem [256];
  int tb_last = 1;     // reference arbiter memory
  bit arm_force = 0;   // hold snd_ready low for 20 cycles after next read
  bit slow_snd = 0;    // long sender service time

  // Memory model: data appears the cycle after the strobe, noise otherwise.
  initial begin
    logic rd; logic [ADDR_W-1:0] ra;
    mem_rd_data = '0;
    forever begin
      @(negedge clk); rd = mem_rd_en; ra = mem_addr;
      @(posedge clk); #1;
      if (rd) mem_rd_data = mem[ra];
      else    mem_rd_data = $urandom;
    end
  end

  // Sender model: busy for a random time after each command, then done.
  initial begin
    bit cmd, sbusy, fired; int scnt, force_lo;
    snd_ready = 1'b0; snd_done = 1'b0; sbusy = 0; scnt = 0; force_lo = 0; fired = 0;
    forever begin
      @(negedge clk);
      cmd = rst_n && (snd_start || snd_newline);
      if (!arm_force) fired = 0;
      else if (!fired && mem_rd_en) begin force_lo = 20; fired = 1; end
      @(posedge clk); #1;
      if (!rst_n) begin
        sbusy = 0; snd_done = 1'b0; snd_ready = 1'b0; force_lo = 0;
      end else begin
        snd_done = 1'b0;
        if (cmd) begin
          sbusy = 1; scnt = slow_snd ? 8 : $urandom_range(0, 3);
        end else if (sbusy) begin
          if (scnt == 0) begin snd_done = 1'b1; sbusy = 0; end
          else scnt--;
        end
        if (force_lo > 0) force_lo--;
        snd_ready = !sbusy && !snd_done && (force_lo == 0);
      end
    end
  end

  // Monitor: the only process that counts and reports comparisons.
  always @(negedge clk) begin
    chk_t k; cmd_t e; ack_t x; logic [ADDR_W-1:0] a; bit ok;
    while (chk_q.size() > 0) begin
      k = chk_q.pop_front();
      tests++;
      if (k.act !== k.exp) begin
        fails++;
        $display("FAIL %s: got %0h, expected %0h", k.name, k.act, k.exp);
      end
    end
    if (rst_n) begin
      if (mem_rd_en) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++; $display("FAIL unexpected_read: addr %0h, no read expected", mem_addr);
        end else begin
          a = rd_q.pop_front();
          if (mem_addr !== a) begin
            fails++; $display("FAIL rd_addr: got %0h, expected %0h", mem_addr, a);
          end
        end
      end
      if (snd_start || snd_newline) begin
        tests++;
        if (snd_ready !== 1'b1) begin
          fails++; $display("FAIL cmd_ready: command issued with snd_ready=%0b, expected 1", snd_ready);
        end
        tests++;
        if (cmd_q.size() == 0) begin
          fails++; $display("FAIL unexpected_cmd: start=%0b nl=%0b data=%0h, none expected",
                            snd_start, snd_newline, snd_data);
        end else begin
          e = cmd_q.pop_front();
          if (e.nl) ok = snd_newline && !snd_start;
          else      ok = snd_start && !snd_newline && (snd_send_id == e.sid) &&
                         (snd_last_col == e.lc) && (snd_data == e.d);
          if (!ok) begin
            fails++;
            $display("FAIL cmd: got start=%0b nl=%0b sid=%0b lc=%0b data=%0h, expected nl=%0b sid=%0b lc=%0b data=%0h",
                     snd_start, snd_newline, snd_send_id, snd_last_col, snd_data, e.nl, e.sid, e.lc, e.d);
          end
        end
      end
      if (ack != 2'b00 || err) begin
        tests++;
        if (ack_q.size() == 0) begin
          fails++; $display("FAIL unexpected_ack: ack=%b err=%0b, none expected", ack, err);
        end else begin
          x = ack_q.pop_front();
          if ({ack, err, busy} !== {x.a, x.e, 1'b1}) begin
            fails++; $display("FAIL ack: got ack=%b err=%0b busy=%0b, expected ack=%b err=%0b busy=1",
                              ack, err, busy, x.a, x.e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_t k;
    k.name = nm; k.act = act; k.exp = exp;
    chk_q.push_back(k);
  endtask

  function automatic logic [63:0] out_vec();
    return {14'b0, ack, err, busy, grant, mem_rd_en, mem_addr, snd_start, snd_data,
            snd_last_col, snd_send_id, snd_newline};
  endfunction

  task automatic set_slot(input int s, input int base, input int rows, input int cols,
                          input logic [DATA_W-1:0] id, input bit show);
    req_base[s*ADDR_W +: ADDR_W] = base[ADDR_W-1:0];
    req_rows[s*DIM_W +: DIM_W]   = rows[DIM_W-1:0];
    req_cols[s*DIM_W +: DIM_W]   = cols[DIM_W-1:0];
    req_id[s*DATA_W +: DATA_W]   = id;
    req_show_id[s]               = show;
  endtask

  // Reference: what one print request must produce, from the matrix shape.
  task automatic push_job(input int s, input int base, input int rows, input int cols,
                          input logic [DATA_W-1:0] id, input bit show);
    cmd_t c; ack_t a; int ad;
    a.a = (s == 1) ? 2'b10 : 2'b01;
    a.e = (rows == 0) || (cols == 0);
    if (!a.e) begin
      if (show) begin c.nl = 0; c.sid = 1; c.lc = 1; c.d = id; cmd_q.push_back(c); end
      for (int i = 0; i < rows * cols; i++) begin
        ad = (base + i) % 256;
        rd_q.push_back(ad[ADDR_W-1:0]);
        c.nl = 0; c.sid = 0; c.lc = ((i % cols) == cols - 1); c.d = mem[ad];
        cmd_q.push_back(c);
      end
      if (TRAIL_NL != 0) begin c.nl = 1; c.sid = 0; c.lc = 0; c.d = '0; cmd_q.push_back(c); end
    end
    ack_q.push_back(a);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    chk("reset_outputs", out_vec(), 64'd0);
    req = 2'b00;
    cmd_q.delete(); ack_q.delete(); rd_q.delete();
    tb_last = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_job(input int s, input int base, input int rows, input int cols,
                         input logic [DATA_W-1:0] id, input bit show, input int bound);
    int n; bit got, seen;
    set_slot(s, base, rows, cols, id, show);
    push_job(s, base, rows, cols, id, show);
    tb_last = s;
    req[s] = 1'b1; n = 0; got = 0; seen = 0;
    while (!got && n < bound) begin
      @(negedge clk); n++;
      if (busy && !seen) begin
        seen = 1;
        // Inputs are free to change once the request is latched.
        set_slot(s, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom, $urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) req[s] = 1'b0;
      end
      if (ack[s]) begin got = 1; req[s] = 1'b0; end
    end
    chk($sformatf("job_done_s%0d_%0dx%0d", s, rows, cols), {63'd0, got}, 64'd1);
    if (!got) do_reset();
  endtask

  initial begin
    int n, cnt, cur, st_cyc, rd_cyc, s;
    bit got;
    req = 2'b00; req_base = '0; req_rows = '0; req_cols = '0; req_id = '0; req_show_id = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Both slots request continuously from reset, 1x2 each.
    set_slot(0, 8'h40, 1, 2, 32'h11, 1'b0);
    set_slot(1, 8'h50, 1, 2, 32'h22, 1'b0);
    req = 2'b11;
    #1 chk("reset_outputs_initial", out_vec(), 64'd0);
    repeat (3) @(negedge clk);
    cur = tb_last;
    for (int k = 0; k < 3; k++) begin
      cur = 1 - cur;
      if (cur == 0) push_job(0, 8'h40, 1, 2, 32'h11, 1'b0);
      else          push_job(1, 8'h50, 1, 2, 32'h22, 1'b0);
    end
    tb_last = cur;
    rst_n = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 3 && n < 400) begin
      @(negedge clk); n++;
      if (ack != 2'b00) begin cnt++; if (cnt == 3) req = 2'b00; end
    end
    req = 2'b00;
    chk("held_three_acks", cnt, 3);
    repeat (3) @(negedge clk);

    // Directed cases.
    for (int i = 0; i < 6; i++) mem[8'h10 + i] = i + 1;
    run_job(0, 8'h10, 2, 3, 32'h0, 1'b0, 2000);
    mem[8'h80] = -32'sd7;
    run_job(1, 8'h80, 1, 1, 32'd3, 1'b1, 2000);
    run_job(0, 8'h20, 0, 3, 32'h5, 1'b1, 3);
    run_job(1, 8'hFE, 1, 3, 32'h9, 1'b0, 2000);
    run_job(1, 8'h30, 2, 0, 32'h7, 1'b0, 3);
    run_job(1, 8'h60, 5, 5, 32'hABCD, 1'b1, 2000);

    // snd_ready held low for 20 cycles after the first element read.
    arm_force = 1;
    set_slot(0, 8'h90, 1, 2, 32'h0, 1'b0);
    push_job(0, 8'h90, 1, 2, 32'h0, 1'b0);
    tb_last = 0;
    req[0] = 1'b1; n = 0; got = 0; st_cyc = -1; rd_cyc = -1;
    while (!got && n < 500) begin
      @(negedge clk); n++;
      if (mem_rd_en && rd_cyc < 0) rd_cyc = n;
      if (snd_start && st_cyc < 0) st_cyc = n;
      if (ack[0]) begin got = 1; req[0] = 1'b0; end
    end
    arm_force = 0;
    chk("defer_done", {63'd0, got}, 64'd1);
    chk("defer_start_ge20", {63'd0, (rd_cyc >= 0) && (st_cyc - rd_cyc >= 20)}, 64'd1);
    if (!got) do_reset();

    // Randomized requests.
    for (int t = 0; t < 30; t++) begin
      run_job($urandom_range(0, 1), $urandom_range(0, 255),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5),
              $urandom, $urandom_range(0, 1), 2000);
    end

    // Reset while waiting on the sender: abort with no ack.
    slow_snd = 1;
    s = $urandom_range(0, 1);
    set_slot(s, 8'hC0, 2, 2, 32'h0, 1'b0);
    push_job(s, 8'hC0, 2, 2, 32'h0, 1'b0);
    req[s] = 1'b1; n = 0; got = 0;
    while (!got && n < 200) begin
      @(negedge clk); n++;
      if (snd_start) got = 1;
    end
    chk("abort_first_cmd", {63'd0, got}, 64'd1);
    @(negedge clk);
    do_reset();
    slow_snd = 0;
    repeat (20) @(negedge clk);
    run_job(0, 8'h44, 1, 2, 32'h55, 1'b1, 2000);

    repeat (5) @(negedge clk);
    chk("leftover_cmds", cmd_q.size(), 0);
    chk("leftover_reads", rd_q.size(), 0);
    chk("leftover_acks", ack_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_print_sched.md
Name: matrix_print_sched

Overview:
Arbitrates between two matrix-print requesters (slot 0 = matrix_gen, slot 1 = ALU result path) for the single matrix_uart_sender.
Walks the granted matrix out of a shared row-major matrix store through a 1-cycle-latency read port.
Issues one sender command per element, with the row-end flag, an optional ID line first and an optional trailing blank line.
Pulses a per-requester ack when the whole matrix has been transmitted.

Parameters:
ADDR_W, 8, matrix-store address width
DATA_W, 32, element width (signed); equals the sender data width
DIM_W, 3, row/column count width (legal dimensions 1..5)
TRAIL_NL, 1, 1 = send a blank line after the last row

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  2  per-requester print request, level; held until ack
req_base  in  2*ADDR_W  start address per requester ([ADDR_W-1:0] = slot 0)
req_rows  in  2*DIM_W  row count per requester
req_cols  in  2*DIM_W  column count per requester
req_id  in  2*DATA_W  matrix ID per requester
req_show_id  in  2  1 = print an ID line before the matrix
ack  out  2  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse, coincident with ack, when rows or cols is 0
busy  out  1  high from grant until the ack cycle inclusive
grant  out  1  index of the current/last granted requester
mem_rd_en  out  1  store read strobe
mem_addr  out  ADDR_W  store read address
mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
snd_start  out  1  sender number command pulse
snd_data  out  DATA_W  value to print; stable from pulse until snd_done
snd_last_col  out  1  row-end flag; sender appends newline
snd_send_id  out  1  ID mode; no padding
snd_newline  out  1  newline-only command pulse
snd_ready  in  1  sender idle
snd_done  in  1  sender completion pulse, exactly one per command

Behaviour:
- Reset: every output is 0; state IDLE; last-grant register = 1, so slot 0 wins the first tie. Reset mid-transfer aborts immediately with no ack. The sender is reset by the same rst_n.
- States: IDLE, GRANT, ID_CMD, ID_WAIT, RD_ADDR, RD_DATA, EL_CMD, EL_WAIT, NL_CMD, NL_WAIT, FINISH.
- IDLE: if any req bit is set, select a requester round-robin (the one not granted last when both are set). Latch base, rows, cols, id, show_id and go to GRANT. The latched values are used thereafter; requester inputs may change freely.
- GRANT: busy=1, grant updated.
  - rows==0 or cols==0 -> FINISH with err.
  - else show_id -> ID_CMD.
  - else RD_ADDR.
  - Clear the row counter r and column counter c; set addr = base.
- ID_CMD: wait for snd_ready, then drive snd_start=1, snd_send_id=1, snd_last_col=1, snd_data=id for one cycle -> ID_WAIT.
- Command rule (every *_CMD state): assert exactly one command pulse, only in a cycle where snd_ready=1, then go to the matching *_WAIT.
- Wait rule (every *_WAIT state): stay until snd_done. snd_done seen in any other state is ignored.
- ID_WAIT: on snd_done -> RD_ADDR.
- RD_ADDR: mem_rd_en=1, mem_addr=addr -> RD_DATA.
- RD_DATA: capture mem_rd_data into the snd_data register -> EL_CMD.
- EL_CMD: snd_start=1, snd_last_col=(c==cols-1) -> EL_WAIT.
- EL_WAIT: on snd_done, addr+1 (wraps modulo 2^ADDR_W).
  - c!=cols-1: c+1, then RD_ADDR.
  - c==cols-1, r!=rows-1: c=0, r+1, then RD_ADDR.
  - last element: NL_CMD if TRAIL_NL, else FINISH.
- Address generation: running increment only, no multiplier.
- NL_CMD: snd_newline=1 pulse -> NL_WAIT. NL_WAIT: on snd_done -> FINISH.
- FINISH: ack[grant]=1 for one cycle (plus err if flagged), busy=1 this cycle -> IDLE. The next arbitration happens in the following cycle. The requester must drop req in the cycle after ack, otherwise it is granted again.
- req dropped mid-transfer: ignored; the transfer completes and ack still pulses.
- snd_data and snd_last_col hold their values until the next command.
- Minimum per-element overhead: 3 cycles plus sender time.

Test Plan:
- Slot 0: base=0x10, 2x3, store 1..6, show_id=0 -> elements 1,2,3(last_col),4,5,6(last_col) are read from 0x10..0x15; then one newline; ack[0] pulses once; UART shows 2 lines plus a blank line.
- Slot 1: 1x1, data=-7, show_id=1, id=3 -> ID command data=3 with send_id=1, then element -7 with last_col=1, newline, ack[1].
- req=2'b11 held from reset, each 1x2 -> slot 0 is served first, then slot 1, then slot 0 again; ack alternates 0,1,0.
- rows=0 on slot 0 -> no sender commands, no mem reads; ack[0] and err pulse within 3 cycles of req.
- base=0xFE, 1x3 -> reads 0xFE, 0xFF, 0x00 (wrap).
- snd_ready held low for 20 cycles after an element read -> snd_start is deferred to the first ready cycle and issued exactly once; rst_n asserted mid-EL_WAIT -> all outputs 0 and no ack.
